part2_mac: RTL and testbench



---
 rtl/part2_mac_pkg.sv | 37 +++
 rtl/part2_mac_in_reg.sv | 35 +++
 rtl/part2_mac.sv | 70 +++++++
 tb/tb_part2_mac.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/part2_mac_pkg.sv
// Shared widths, operand/accumulator types and the wrap/clamp rule for part2_mac.
package part2_mac_pkg;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_ACC_W = 16;

    typedef logic signed [DEF_IN_W-1:0]   operand_t;
    typedef logic signed [2*DEF_IN_W-1:0] prod_t;
    typedef logic signed [DEF_ACC_W-1:0]  acc_t;

    // Wide carrier so a single function serves any ACC_W up to 62 bits.
    typedef logic signed [63:0] wide_t;

    function automatic wide_t sat_add(input wide_t acc, input wide_t product,
                                      input int acc_w, input bit saturate);
        wide_t sum;
        wide_t max_v;
        wide_t min_v;
        wide_t wrapped;
        int    sh;
        sum     = acc + product;
        max_v   = (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
        min_v   = -max_v - wide_t'(1);
        sh      = 64 - acc_w;
        // Shift up then arithmetic shift down keeps the low acc_w bits, sign-extended.
        wrapped = (sum <<< sh) >>> sh;
        if (!saturate) begin
            return wrapped;
        end else if (sum > max_v) begin
            return max_v;
        end else if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/part2_mac_in_reg.sv
// Stage-1 capture of operands and valid; no enable, reset clears everything.
module part2_mac_in_reg #(
    parameter int IN_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [IN_W-1:0] a_i,
    input  logic signed [IN_W-1:0] b_i,
    input  logic                   valid_i,
    output logic signed [IN_W-1:0] a_o,
    output logic signed [IN_W-1:0] b_o,
    output logic                   valid_o
);

    logic signed [IN_W-1:0] a_q;
    logic signed [IN_W-1:0] b_q;
    logic                   valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_i;
            b_q     <= b_i;
            valid_q <= valid_i;
        end
    end

    assign a_o     = a_q;
    assign b_o     = b_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/part2_mac.sv
// Two-stage signed multiply-accumulate: registered operands, then wrap or clamp accumulate.
module part2_mac
    import part2_mac_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    input  logic                    valid_in,
    output logic signed [ACC_W-1:0] f,
    output logic                    valid_out
);

    typedef logic signed [ACC_W-1:0] f_t;

    logic signed [IN_W-1:0]   a_r;
    logic signed [IN_W-1:0]   b_r;
    logic                     v_r;
    logic signed [2*IN_W-1:0] prod;
    wide_t                    acc_ext;
    wide_t                    prod_ext;
    f_t                       f_q;
    f_t                       f_d;
    logic                     valid_q;
    logic                     valid_d;

    part2_mac_in_reg #(
        .IN_W(IN_W)
    ) u_in_reg (
        .clk    (clk),
        .reset  (reset),
        .a_i    (a),
        .b_i    (b),
        .valid_i(valid_in),
        .a_o    (a_r),
        .b_o    (b_r),
        .valid_o(v_r)
    );

    assign prod     = a_r * b_r;
    assign acc_ext  = {{(64-ACC_W){f_q[ACC_W-1]}}, f_q};
    assign prod_ext = {{(64-2*IN_W){prod[2*IN_W-1]}}, prod};

    always_comb begin
        f_d     = f_q;
        valid_d = 1'b0;
        if (v_r) begin
            f_d     = f_t'(sat_add(acc_ext, prod_ext, ACC_W, SATURATE != 0));
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            f_q     <= f_d;
            valid_q <= valid_d;
        end
    end

    assign f         = f_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_part2_mac.sv
// Drives a wrapping and a saturating part2_mac in lockstep against a sample-queue reference model.
module tb_part2_mac;
    import part2_mac_pkg::*;

    logic     clk = 1'b0;
    logic     reset;
    operand_t a;
    operand_t b;
    logic     valid_in;
    acc_t     f_wrap;
    acc_t     f_sat;
    logic     vo_wrap;
    logic     vo_sat;

    always #5 clk = ~clk;

    part2_mac #(.IN_W(8), .ACC_W(16), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in),
        .f(f_wrap), .valid_out(vo_wrap)
    );

    part2_mac #(.IN_W(8), .ACC_W(16), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in),
        .f(f_sat), .valid_out(vo_sat)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit v;
        int p;
    } samp_t;

    // Samples captured but not yet accumulated (one edge of delay).
    samp_t pend[$];
    int    acc_w_m = 0;
    int    acc_s_m = 0;
    int    exp_v   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int wrap16(input int s);
        if (s > 32767)  return s - 65536;
        if (s < -32768) return s + 65536;
        return s;
    endfunction

    function automatic int clamp16(input int s);
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    task automatic step(input int ai, input int bi, input bit vi, input bit ri);
        samp_t cap;
        samp_t cur;
        a        = operand_t'(ai);
        b        = operand_t'(bi);
        valid_in = vi;
        reset    = ri;
        @(posedge clk);
        #1;
        if (ri) begin
            acc_w_m = 0;
            acc_s_m = 0;
            exp_v   = 0;
            pend.delete();
            cur.v = 1'b0;
            cur.p = 0;
            pend.push_back(cur);
        end else begin
            cap = pend.pop_front();
            if (cap.v) begin
                acc_w_m = wrap16(acc_w_m + cap.p);
                acc_s_m = clamp16(acc_s_m + cap.p);
            end
            exp_v = cap.v ? 1 : 0;
            cur.v = vi;
            cur.p = ai * bi;
            pend.push_back(cur);
        end
        check("wrap_f", int'(f_wrap), acc_w_m);
        check("sat_f", int'(f_sat), acc_s_m);
        check("wrap_vo", int'(vo_wrap), exp_v);
        check("sat_vo", int'(vo_sat), exp_v);
        $display("t=%0t a=%0d b=%0d v=%0d rst=%0d -> f_wrap=%0d f_sat=%0d vo=%0d/%0d",
                 $time, ai, bi, vi, ri, f_wrap, f_sat, vo_wrap, vo_sat);
    endtask

    initial begin
        a        = '0;
        b        = '0;
        valid_in = 1'b0;
        reset    = 1'b1;

        // Idle after reset
        step(0, 0, 0, 1);
        repeat (3) begin
            step(0, 0, 0, 0);
            check("idle_f", int'(f_wrap), 0);
            check("idle_vo", int'(vo_wrap), 0);
        end

        // Mixed valid/invalid sequence
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        step(2, 2, 1, 0);
        step(3, 3, 1, 0);
        check("seq_f4", int'(f_wrap), 4);
        check("seq_vo4", int'(vo_wrap), 1);
        step(4, 4, 0, 0);
        check("seq_f13", int'(f_wrap), 13);
        step(5, 5, 0, 0);
        check("seq_hold_f", int'(f_wrap), 13);
        check("seq_hold_vo", int'(vo_wrap), 0);
        step(6, 6, 1, 0);
        step(0, 0, 0, 0);
        check("seq_f49", int'(f_wrap), 49);
        check("seq_vo49", int'(vo_wrap), 1);

        // Signed operands including the most negative product
        step(0, 0, 0, 1);
        step(-3, 5, 1, 0);
        step(-128, -128, 1, 0);
        check("signed_f1", int'(f_wrap), -15);
        step(0, 0, 0, 0);
        check("signed_f2", int'(f_wrap), 16369);
        check("signed_f2_sat", int'(f_sat), 16369);

        // Overflow: wrap versus clamp
        step(0, 0, 0, 1);
        step(127, 127, 1, 0);
        step(127, 127, 1, 0);
        check("ovf_1", int'(f_wrap), 16129);
        step(127, 127, 1, 0);
        check("ovf_2_wrap", int'(f_wrap), 32258);
        check("ovf_2_sat", int'(f_sat), 32258);
        step(-128, 127, 1, 0);
        check("ovf_3_wrap", int'(f_wrap), -17149);
        check("ovf_3_sat", int'(f_sat), 32767);
        step(0, 0, 0, 0);
        check("ovf_4_sat", int'(f_sat), 16511);
        check("ovf_4_wrap", int'(f_wrap), 32131);

        // Reset right after a valid sample discards it
        step(0, 0, 0, 1);
        step(7, 7, 1, 0);
        step(0, 0, 0, 1);
        check("midrst_f", int'(f_wrap), 0);
        check("midrst_vo", int'(vo_wrap), 0);
        step(0, 0, 0, 0);
        check("midrst_after_f", int'(f_wrap), 0);
        check("midrst_after_vo", int'(vo_wrap), 0);

        // Reset wins over a concurrent valid sample
        step(5, 5, 1, 1);
        step(0, 0, 0, 0);
        check("rstprio_vo", int'(vo_wrap), 0);
        check("rstprio_f", int'(f_sat), 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            step(int'($urandom_range(255, 0)) - 128,
                 int'($urandom_range(255, 0)) - 128,
                 $urandom_range(3, 0) != 0,
                 $urandom_range(49, 0) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
